// File: rtl/wb_master_pkg.sv
// Shared types and constants for the single-outstanding Wishbone classic initiator.
//   wb_state_e           : initiator FSM states (idle / bus cycle open / response held)
//   WB_ADR_W/DAT_W/SEL_W : Wishbone address, data and byte-select widths
//   TIMEOUT_DATA_DEFAULT : read data reported for a cycle the watchdog aborted
package wb_master_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    localparam logic [WB_DAT_W-1:0] TIMEOUT_DATA_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } wb_state_e;

endpackage

// File: rtl/wb_watchdog_ctr.sv
// Watchdog for an open Wishbone cycle.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : return the count to zero (takes priority over enable_i)
//   enable_i     : count one cycle
//   expired_o    : count has reached TIMEOUT_CYCLES-1, i.e. this is the last allowed cycle
// TIMEOUT_CYCLES = 0 disables the watchdog: expired_o is held low.
module wb_watchdog_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    // One bit minimum so the disabled configuration still elaborates cleanly.
    localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntTerm = (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CntMax)) begin
            // Saturate instead of wrapping so a stuck enable can never re-arm.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT_CYCLES != 0) && (cnt_q == CntTerm);

endmodule

// File: rtl/wb_simple_master.sv
// Single-outstanding Wishbone classic initiator bridging a valid/ready command/response
// interface onto a Wishbone bus, with a watchdog that aborts cycles never acknowledged.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o : command handshake (ready only while idle)
//   cmd_we_i/adr_i/dat_i/sel_i : command fields, latched on acceptance
//   rsp_valid_o/rsp_ready_i : response handshake
//   rsp_dat_o               : read data, 0 for writes, TIMEOUT_DATA on abort
//   rsp_timeout_o           : response came from a watchdog abort
//   cyc_o/stb_o/we_o/sel_o/adr_o/dat_o, ack_i/dat_i : Wishbone initiator side
module wb_simple_master
    import wb_master_pkg::*;
#(
    parameter int unsigned          TIMEOUT_CYCLES = 256,
    parameter logic [WB_DAT_W-1:0]  TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [WB_ADR_W-1:0] cmd_adr_i,
    input  logic [WB_DAT_W-1:0] cmd_dat_i,
    input  logic [WB_SEL_W-1:0] cmd_sel_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [WB_DAT_W-1:0] rsp_dat_o,
    output logic                rsp_timeout_o,
    output logic                cyc_o,
    output logic                stb_o,
    output logic                we_o,
    output logic [WB_SEL_W-1:0] sel_o,
    output logic [WB_ADR_W-1:0] adr_o,
    output logic [WB_DAT_W-1:0] dat_o,
    input  logic                ack_i,
    input  logic [WB_DAT_W-1:0] dat_i
);

    wb_state_e             state_q, state_d;
    logic                  we_q, we_d;
    logic [WB_ADR_W-1:0]   adr_q, adr_d;
    logic [WB_DAT_W-1:0]   dat_q, dat_d;
    logic [WB_SEL_W-1:0]   sel_q, sel_d;
    logic [WB_DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  wd_expired;

    // Counts only while the cycle is open; leaving BUS restarts it for the next command.
    wb_watchdog_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q != StBus),
        .enable_i  (state_q == StBus),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        adr_d         = adr_q;
        dat_d         = dat_q;
        sel_d         = sel_q;
        rsp_dat_d     = rsp_dat_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    sel_d   = cmd_sel_i;
                    state_d = StBus;
                end
            end
            StBus: begin
                // A late ack on the terminal watchdog cycle still completes normally.
                if (ack_i) begin
                    rsp_dat_d     = we_q ? '0 : dat_i;
                    rsp_timeout_d = 1'b0;
                    state_d       = StResp;
                end else if (wd_expired) begin
                    rsp_dat_d     = TIMEOUT_DATA;
                    rsp_timeout_d = 1'b1;
                    state_d       = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            we_q          <= 1'b0;
            adr_q         <= '0;
            dat_q         <= '0;
            sel_q         <= '0;
            rsp_dat_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            adr_q         <= adr_d;
            dat_q         <= dat_d;
            sel_q         <= sel_d;
            rsp_dat_q     <= rsp_dat_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Handshake and strobe outputs decode straight from the state register, so an
    // asynchronous reset drops cyc_o/stb_o without waiting for a clock edge.
    assign cmd_ready_o   = (state_q == StIdle);
    assign rsp_valid_o   = (state_q == StResp);
    assign cyc_o         = (state_q == StBus);
    assign stb_o         = (state_q == StBus);
    assign we_o          = we_q;
    assign adr_o         = adr_q;
    assign dat_o         = dat_q;
    assign sel_o         = sel_q;
    assign rsp_dat_o     = rsp_dat_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_wb_simple_master.sv
// Bench for wb_simple_master: registered-ack dummy responder, transaction-level reference
// model compared every cycle, plus directed literal checks and randomized traffic.
module tb_wb_simple_master;

    localparam int unsigned Tmo       = 16;
    localparam logic [31:0] TmoData   = 32'hFFFF_FFFF;
    localparam logic [31:0] EmptyData = 32'hDEAD_BEEF;
    localparam logic [31:0] StrayData = 32'h1234_5678;
    localparam logic [31:0] Base      = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;
    logic        ack_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_simple_master #(
        .TIMEOUT_CYCLES (Tmo),
        .TIMEOUT_DATA   (TmoData)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_we_i      (cmd_we),
        .cmd_adr_i     (cmd_adr),
        .cmd_dat_i     (cmd_dat),
        .cmd_sel_i     (cmd_sel),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_dat_o     (rsp_dat),
        .rsp_timeout_o (rsp_timeout),
        .cyc_o         (cyc),
        .stb_o         (stb),
        .we_o          (we),
        .sel_o         (sel),
        .adr_o         (adr),
        .dat_o         (dat_o),
        .ack_i         (ack_i),
        .dat_i         (dat_i)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nd[b*8 +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_expired(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- dummy responder (registered ack, 4-word memory) ----------------
    bit          ack_en = 1'b1;
    logic        stray_ack = 1'b0;
    logic        ack_q;
    logic [31:0] mem [4];
    logic [3:0]  mem_vld;

    function automatic logic [31:0] dev_rd(input logic [1:0] i);
        return mem_vld[i] ? mem[i] : EmptyData;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_en && cyc && stb && !ack_q;
            if (ack_q && cyc && stb && we) begin
                mem[adr[3:2]]     <= merge(dev_rd(adr[3:2]), dat_o, sel);
                mem_vld[adr[3:2]] <= 1'b1;
            end
        end
    end

    assign ack_i = ack_q | stray_ack;
    assign dat_i = stray_ack ? StrayData : dev_rd(adr[3:2]);

    // ---------------- transaction-level reference model ----------------
    // Outcome of each command is decided at acceptance from the reference memory and the
    // responder mode; the model then just runs out the known number of bus cycles.
    int          m_phase = 0;  // 0 waiting for command, 1 bus cycle open, 2 response held
    int          m_left  = 0;
    logic        m_we = 1'b0;
    logic [31:0] m_adr = '0, m_dat = '0, m_rdat = '0, m_next_rdat = '0;
    logic [3:0]  m_sel = '0;
    logic        m_tmo = 1'b0, m_next_tmo = 1'b0;
    logic [31:0] ref_mem [4];
    logic [3:0]  ref_vld = '0;

    function automatic logic [31:0] ref_rd(input logic [1:0] i);
        return ref_vld[i] ? ref_mem[i] : EmptyData;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_we    <= 1'b0;
            m_adr   <= '0;
            m_dat   <= '0;
            m_sel   <= '0;
            m_rdat  <= '0;
            m_tmo   <= 1'b0;
        end else begin
            case (m_phase)
                0: if (cmd_valid) begin
                    m_we    <= cmd_we;
                    m_adr   <= cmd_adr;
                    m_dat   <= cmd_dat;
                    m_sel   <= cmd_sel;
                    m_phase <= 1;
                    if (ack_en) begin
                        m_left      <= 2;
                        m_next_tmo  <= 1'b0;
                        m_next_rdat <= cmd_we ? 32'h0 : ref_rd(cmd_adr[3:2]);
                        if (cmd_we) begin
                            ref_mem[cmd_adr[3:2]] <= merge(ref_rd(cmd_adr[3:2]), cmd_dat,
                                                           cmd_sel);
                            ref_vld[cmd_adr[3:2]] <= 1'b1;
                        end
                    end else begin
                        m_left      <= Tmo;
                        m_next_tmo  <= 1'b1;
                        m_next_rdat <= TmoData;
                    end
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= 2;
                        m_rdat  <= m_next_rdat;
                        m_tmo   <= m_next_tmo;
                    end
                end
                default: if (rsp_ready) m_phase <= 0;
            endcase
        end
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        check("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
        check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
        check("cyc", 32'(cyc), 32'(m_phase == 1));
        check("stb", 32'(stb), 32'(m_phase == 1));
        check("we_o", 32'(we), 32'(m_we));
        check("adr_o", adr, m_adr);
        check("dat_o", dat_o, m_dat);
        check("sel_o", 32'(sel), 32'(m_sel));
        check("rsp_dat", rsp_dat, m_rdat);
        check("rsp_timeout", 32'(rsp_timeout), 32'(m_tmo));
    end

    // ---------------- stimulus ----------------
    // Issues one command, returns what the response carried, how many strobe cycles were
    // seen and the cycle (1 = first cycle after the accept edge) in which rsp_valid rose.
    task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold, input bit stray_resp,
                          output logic [31:0] rd, output logic to, output int stbn,
                          output int lat);
        bit ok;
        rd = '0; to = 1'b0; stbn = 0; lat = 0;
        @(posedge clk); #2;
        cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
        rsp_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin bound_expired("accept"); cmd_valid = 1'b0; return; end
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        cmd_dat   = $urandom;
        ok = 1'b0;
        for (int n = 1; n < 100; n++) begin
            @(negedge clk);
            if (stb) stbn++;
            if (rsp_valid) begin
                lat = n; rd = rsp_dat; to = rsp_timeout; ok = 1'b1;
                break;
            end
        end
        if (!ok) begin bound_expired("response"); return; end
        for (int h = 0; h < hold; h++) begin
            if (stray_resp && h == 0) stray_ack = 1'b1;
            @(negedge clk);
            stray_ack = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        rsp_ready = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) bound_expired(name);
    endtask

    initial begin
        logic [31:0] rd, held;
        logic        to;
        int          stbn, lat, j;
        bit          ok;

        // Reset and reset-state literals.
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset cyc", 32'(cyc), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_dat", rsp_dat, 32'd0);
        #3 rst = 1'b0;

        // Read straight after reset: responder has nothing stored.
        do_cmd(1'b0, Base, 32'h0, 4'hF, 0, 1'b0, rd, to, stbn, lat);
        check("first read data", rd, 32'hDEAD_BEEF);
        check("first read timeout", 32'(to), 32'd0);

        // Write then read back.
        do_cmd(1'b1, Base, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, rd, to, stbn, lat);
        check("write stb cycles", 32'(stbn), 32'd2);
        check("write we_o", 32'(we), 32'd1);
        check("write timeout", 32'(to), 32'd0);
        check("write rsp data", rd, 32'd0);
        do_cmd(1'b0, Base, 32'h0, 4'hF, 0, 1'b0, rd, to, stbn, lat);
        check("read data", rd, 32'hA5A5_5A5A);
        check("read latency", 32'(lat), 32'd3);

        // Watchdog abort, then a normal command.
        @(posedge clk); #2 ack_en = 1'b0;
        do_cmd(1'b0, Base + 32'h8, 32'h0, 4'hF, 0, 1'b0, rd, to, stbn, lat);
        check("timeout stb cycles", 32'(stbn), 32'd16);
        check("timeout data", rd, 32'hFFFF_FFFF);
        check("timeout flag", 32'(to), 32'd1);
        ack_en = 1'b1;
        do_cmd(1'b0, Base, 32'h0, 4'hF, 0, 1'b0, rd, to, stbn, lat);
        check("after timeout data", rd, 32'hA5A5_5A5A);
        check("after timeout flag", 32'(to), 32'd0);

        // Backpressure with a second command waiting.
        @(posedge clk); #2;
        cmd_we = 1'b0; cmd_adr = Base; cmd_sel = 4'hF; cmd_valid = 1'b1; rsp_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) bound_expired("bp accept");
        @(posedge clk); #2;
        cmd_we = 1'b1; cmd_adr = Base + 32'h4; cmd_dat = 32'h0BAD_F00D;
        wait_rsp("bp response");
        held = rsp_dat;
        check("bp data", held, 32'hA5A5_5A5A);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp rsp_dat stable", rsp_dat, 32'hA5A5_5A5A);
            check("bp cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp no cyc", 32'(cyc), 32'd0);
        end
        rsp_ready = 1'b1;
        j = 0;
        ok = 1'b0;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin j = i; ok = 1'b1; break; end
        end
        if (!ok) bound_expired("bp re-accept");
        check("bp accept after handshake", 32'(j), 32'd1);
        @(posedge clk); #2;
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        wait_rsp("bp second response");
        check("bp second data", rsp_dat, 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #2 rsp_ready = 1'b0;

        // Asynchronous reset while the bus cycle is open.
        ack_en = 1'b0;
        do_cmd(1'b1, Base + 32'hC, 32'h1, 4'hF, 0, 1'b0, rd, to, stbn, lat);
        ack_en = 1'b1;
        @(posedge clk); #2;
        cmd_we = 1'b0; cmd_adr = Base; cmd_valid = 1'b1;
        ack_en = 1'b0;
        @(posedge clk); #2 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("async rst cyc", 32'(cyc), 32'd0);
        check("async rst stb", 32'(stb), 32'd0);
        check("async rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("async rst cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk); #3 rst = 1'b0;
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        check("post rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("post rst rsp_valid", 32'(rsp_valid), 32'd0);

        // Stray acks in IDLE and in RESP.
        do_cmd(1'b0, Base, 32'h0, 4'hF, 0, 1'b0, rd, to, stbn, lat);
        held = rsp_dat;
        @(posedge clk); #2 stray_ack = 1'b1;
        @(posedge clk); #2 stray_ack = 1'b0;
        @(negedge clk);
        check("stray idle rsp_dat", rsp_dat, held);
        check("stray idle cyc", 32'(cyc), 32'd0);
        do_cmd(1'b0, Base, 32'h0, 4'hF, 3, 1'b1, rd, to, stbn, lat);
        check("stray resp data", rsp_dat, 32'hA5A5_5A5A);

        // Randomized traffic, checked by the every-cycle compare.
        for (int t = 0; t < 40; t++) begin
            logic [1:0] idx;
            idx = 2'($urandom_range(0, 3));
            @(posedge clk); #2;
            ack_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) begin
                stray_ack = 1'b1;
                @(posedge clk); #2 stray_ack = 1'b0;
            end
            do_cmd(1'($urandom_range(0, 1)), Base + {28'h0, idx, 2'b00}, $urandom,
                   4'($urandom_range(1, 15)), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), rd, to, stbn, lat);
        end
        ack_en = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
